// File: rtl/twiddle_request_sequencer_pkg.sv
// Shared types and float field constants for the twiddle request sequencer.
// State enum, IEEE-style field slices and calculator select codes.
package twiddle_pkg;

  localparam int FLT_EXP_LEN  = 8;
  localparam int FLT_MANT_LEN = 23;
  localparam int FLT_W        = FLT_EXP_LEN + FLT_MANT_LEN + 1;
  localparam int FLT_SIGN_BIT = FLT_W - 1;
  localparam int FLT_EXP_MSB  = FLT_W - 2;
  localparam int FLT_EXP_LSB  = FLT_MANT_LEN;
  localparam int FLT_MANT_MSB = FLT_MANT_LEN - 1;

  localparam logic SEL_SINE   = 1'b1;
  localparam logic SEL_COSINE = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROM_RD,
    S_ROM_WAIT,
    S_REQ_COS,
    S_WAIT_COS,
    S_REQ_SIN,
    S_WAIT_SIN,
    S_EMIT,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/twiddle_request_sequencer_if.sv
// Calculator request/response and twiddle stream bundle.
// master = sequencer side, slave = calculator + butterfly side.
interface twiddle_request_sequencer_if
  import twiddle_pkg::*;
#(
  parameter int W  = FLT_W,
  parameter int IW = 7
);

  logic [W-1:0]  calc_theta;
  logic          calc_sine_cosine;
  logic          calc_req;
  logic [W-1:0]  calc_value;
  logic          calc_done;

  logic          tw_valid;
  logic          tw_ready;
  logic [IW-1:0] tw_idx;
  logic [W-1:0]  tw_cos;
  logic [W-1:0]  tw_sin;

  modport master (
    output calc_theta,
    output calc_sine_cosine,
    output calc_req,
    input  calc_value,
    input  calc_done,
    output tw_valid,
    input  tw_ready,
    output tw_idx,
    output tw_cos,
    output tw_sin
  );

  modport slave (
    input  calc_theta,
    input  calc_sine_cosine,
    input  calc_req,
    output calc_value,
    output calc_done,
    input  tw_valid,
    output tw_ready,
    input  tw_idx,
    input  tw_cos,
    input  tw_sin
  );

endinterface

// File: rtl/twiddle_request_sequencer.sv
// Sweeps angle ROM, requests cos then sin per angle, streams twiddle pairs.
// Optional calculator watchdog: define TWIDDLE_SEQ_TIMEOUT_EN.
module twiddle_request_sequencer
  import twiddle_pkg::*;
#(
  parameter int EXP_LEN        = FLT_EXP_LEN,
  parameter int MANTISSA_LEN   = FLT_MANT_LEN,
  parameter int LOG2_N         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            inverse,
  output logic                            busy,
  output logic                            done,
  output logic [LOG2_N-2:0]               rom_addr,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   rom_data,
  output logic                            error,
  twiddle_request_sequencer_if.master     bus
);

  localparam int W  = EXP_LEN + MANTISSA_LEN + 1;
  localparam int SB = W - 1;
  localparam int IW = LOG2_N - 1;
  localparam logic [IW-1:0] K_LAST = '1;

  if (LOG2_N < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("twiddle_request_sequencer: LOG2_N and TIMEOUT_CYCLES must be >= 2");
  end

  seq_state_e    state;
  logic [IW-1:0] k;
  logic          inv_q;
  logic [W-1:0]  sin_tw;
  logic          wd_fire;

  // Forward transform wants conj twiddles: flip the sign bit unless inverse.
  assign sin_tw = {bus.calc_value[SB] ^ ~inv_q, bus.calc_value[SB-1:0]};

`ifdef TWIDDLE_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          in_wait;

  assign in_wait = (state == S_WAIT_COS) || (state == S_WAIT_SIN);
  assign wd_fire = in_wait && !bus.calc_done
                && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts cycles since the strobe; the REQ cycle itself is cycle 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      error  <= 1'b0;
    end else begin
      if (state == S_REQ_COS || state == S_REQ_SIN)
        wd_cnt <= CW'(1);
      else if (in_wait)
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire)
        error <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      k                    <= '0;
      inv_q                <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      rom_addr             <= '0;
      bus.calc_theta       <= '0;
      bus.calc_sine_cosine <= 1'b0;
      bus.calc_req         <= 1'b0;
      bus.tw_valid         <= 1'b0;
      bus.tw_idx           <= '0;
      bus.tw_cos           <= '0;
      bus.tw_sin           <= '0;
    end else begin
      bus.calc_req <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ROM_RD;
            k        <= '0;
            inv_q    <= inverse;
            busy     <= 1'b1;
            rom_addr <= '0;
          end
        end
        S_ROM_RD: state <= S_ROM_WAIT;
        S_ROM_WAIT: begin
          bus.calc_theta       <= rom_data;
          bus.calc_sine_cosine <= SEL_COSINE;
          bus.calc_req         <= 1'b1;
          state                <= S_REQ_COS;
        end
        S_REQ_COS: state <= S_WAIT_COS;
        S_WAIT_COS: begin
          if (wd_fire) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (bus.calc_done) begin
            bus.tw_cos           <= bus.calc_value;
            bus.calc_sine_cosine <= SEL_SINE;
            bus.calc_req         <= 1'b1;
            state                <= S_REQ_SIN;
          end
        end
        S_REQ_SIN: state <= S_WAIT_SIN;
        S_WAIT_SIN: begin
          if (wd_fire) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (bus.calc_done) begin
            bus.tw_sin   <= sin_tw;
            bus.tw_idx   <= k;
            bus.tw_valid <= 1'b1;
            state        <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.tw_ready) begin
            bus.tw_valid <= 1'b0;
            if (k == K_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              k        <= k + 1'b1;
              rom_addr <= k + 1'b1;
              state    <= S_ROM_RD;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/twiddle_request_sequencer.md
Name: twiddle_request_sequencer

Overview:
- Initiator/client side of the sine_calculator request interface.
- Walks twiddle indices k = 0 .. 2^(LOG2_N-1)-1 and fetches each float angle from an external angle ROM.
- Issues a cosine request, then a sine request, to the trig calculator for each angle.
- Emits the twiddle pair (cos, ±sin) on a valid/ready stream to the NTT/FFT butterfly datapath.

Parameters:
- EXP_LEN, 8, float exponent width.
- MANTISSA_LEN, 23, float mantissa width; word width W = EXP_LEN+MANTISSA_LEN+1.
- LOG2_N, 8, log2 of transform size; twiddle count NTW = 2^(LOG2_N-1).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- inverse  in  1  sampled at start; 0 = forward (emit -sin), 1 = inverse (emit +sin).
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last twiddle handshake.
- rom_addr  out  LOG2_N-1  angle ROM index.
- rom_data  in  W  angle float; valid exactly 1 cycle after rom_addr changes.
- calc_theta  out  W  angle presented to the calculator.
- calc_sine_cosine  out  1  1 = sine, 0 = cosine.
- calc_req  out  1  one-cycle request strobe.
- calc_value  in  W  calculator result.
- calc_done  in  1  one-cycle result strobe.
- tw_valid  out  1  twiddle pair valid.
- tw_ready  in  1  downstream accept.
- tw_idx  out  LOG2_N-1  index k of the presented pair.
- tw_cos  out  W  cos(theta_k).
- tw_sin  out  W  sin(theta_k), sign per inverse.
- error  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at a clk edge) forces all outputs to 0 and the state to IDLE, from any state.
  - Reset mid-sweep abandons the sweep; later calc_done pulses are ignored while in IDLE.
- States:
  - IDLE -> ROM_RD on start. k=0 and inverse are latched.
  - ROM_RD: drive rom_addr=k -> ROM_WAIT.
  - ROM_WAIT: latch theta=rom_data -> REQ_COS.
  - REQ_COS: calc_req=1, calc_sine_cosine=0, calc_theta=theta for exactly 1 cycle -> WAIT_COS.
  - WAIT_COS: on calc_done, latch cos=calc_value -> REQ_SIN.
  - REQ_SIN: as REQ_COS but calc_sine_cosine=1 -> WAIT_SIN.
  - WAIT_SIN: on calc_done, latch sin=calc_value -> EMIT.
  - EMIT: tw_valid=1.
    - On tw_valid&tw_ready: if k=NTW-1 -> DONE, else k+1 -> ROM_RD.
  - DONE: done=1 for 1 cycle -> IDLE.
- Start timing: start at cycle 0 -> busy=1 and rom_addr=0 at cycle 1; first calc_req at cycle 3.
- calc_theta and calc_sine_cosine stay stable from calc_req until the matching calc_done.
- Only one request is outstanding at a time.
- Sign arithmetic: with inverse=0, tw_sin = {~sin[W-1], sin[W-2:0]}. With inverse=1, tw_sin = sin unmodified. Zero therefore becomes 32'h80000000 in forward mode.
- Stream: tw_idx, tw_cos and tw_sin stay stable while tw_valid=1 and tw_ready=0. tw_valid drops the cycle after the handshake.
- start while busy is ignored.
- calc_done outside WAIT_COS/WAIT_SIN is ignored.
- calc_done arriving in the same cycle as calc_req is ignored; a valid response is at least 1 cycle later.
- k wraps only through DONE, never past NTW-1.

Optional Feature:
- Macro TWIDDLE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_COS/WAIT_SIN.
  - If it reaches TIMEOUT_CYCLES without calc_done: error=1 (sticky until reset), tw_valid is not raised, done pulses, and the state returns to IDLE.
- Undefined: wait indefinitely; error is tied to 0.

Decomposition:
- Package twiddle_pkg holds:
  - the state enum;
  - float field localparams (sign/exponent/mantissa slices);
  - the constants SEL_SINE=1 and SEL_COSINE=0.
- No sub-module. The sign-flip is a single assignment inside the block.

Test Plan:
- LOG2_N=3, inverse=0:
  - Stimulus: ROM k -> {32'h00000000, 32'h3F490FDB, 32'h3FC90FDB, 32'h4016CBE4}; calc model answers 2 cycles after each req.
  - Response: 4 pairs with tw_idx 0..3 in order, 8 calc_req pulses alternating sel 0,1, one done, busy low afterward.
- Sign check:
  - Stimulus: calc model returns sin=32'h3F3504F3.
  - Response: inverse=0 emits 32'hBF3504F3; inverse=1 emits 32'h3F3504F3; tw_cos unmodified.
- Backpressure:
  - Stimulus: tw_ready=0 for 5 cycles at k=1.
  - Response: tw_valid held, data stable, no new rom_addr or calc_req until the handshake.
- Stray inputs:
  - Stimulus: start pulsed at cycle 10 of a sweep; spurious calc_done while in EMIT.
  - Response: both ignored, sweep output unchanged.
- Reset mid-sweep:
  - Stimulus: rst_n=0 during WAIT_SIN at k=2.
  - Response: next cycle all outputs 0, state IDLE; a fresh start restarts at k=0.
- Timeout (TWIDDLE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: calc model never responds.
  - Response: error=1 and done pulse 16 cycles after the first calc_req; no tw_valid.
